multiaddr_range_encode: RTL and testbench

Sequential range-to-multi-address encoder. It converts an address interval [start, end) into the minimal ordered sequence of aligned power-of-two {addr, mask} address sets that exactly covers the interval. One set is emitted per cycle over a valid/ready stream. It is the inverse companion of the multi-address decoder: its output sets are directly consumable as {addr, mask} inputs or as address-map rules.

---
 rtl/multiaddr_pkg.sv | 19 +
 rtl/lzc.sv | 35 +++
 rtl/multiaddr_range_encode.sv | 117 +++++++++++
 tb/tb_multiaddr_range_encode.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/multiaddr_pkg.sv
// Shared types and helpers for the range-to-multi-address encoder.
// Addresses up to 64 bits wide are supported by the helpers here.
package multiaddr_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } encode_state_e;

  localparam int unsigned MAX_ADDR_WIDTH = 64;

  typedef logic [MAX_ADDR_WIDTH-1:0] wide_addr_t;

  // Don't-care mask for an aligned power-of-two set of the given size.
  function automatic wide_addr_t pow2_mask(input wide_addr_t size);
    return size - wide_addr_t'(1);
  endfunction

endpackage

// File: rtl/lzc.sv
// Zero counter: trailing zeros (Leading=0) or leading zeros (Leading=1).
// empty is raised for an all-zero input, in which case cnt is 0.
module lzc #(
  parameter int unsigned Width   = 32,
  parameter bit          Leading = 1'b0,
  localparam int unsigned CntW   = $clog2(Width)
) (
  input  logic [Width-1:0] data_i,
  output logic [CntW-1:0]  cnt_o,
  output logic             empty_o
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    cnt_o   = '0;
    empty_o = 1'b1;
    if (Leading) begin
      // Ascending scan: the highest set bit is the last one to write cnt_o.
      for (int i = 0; i < int'(Width); i++) begin
        if (data_i[i]) begin
          cnt_o   = CntW'(int'(Width) - 1 - i);
          empty_o = 1'b0;
        end
      end
    end else begin
      for (int i = int'(Width) - 1; i >= 0; i--) begin
        if (data_i[i]) begin
          cnt_o   = CntW'(i);
          empty_o = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/multiaddr_range_encode.sv
// Splits [start, end) into the minimal ordered list of aligned {addr, mask} sets, one per cycle.
// Define MULTIADDR_ENCODE_ERR_EN to pulse err_o after a rejected (empty/inverted) request.
module multiaddr_range_encode
  import multiaddr_pkg::*;
#(
  parameter int unsigned AddrWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [AddrWidth-1:0] req_start_i,
  input  logic [AddrWidth-1:0] req_end_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  output logic [AddrWidth-1:0] addr_o,
  output logic [AddrWidth-1:0] mask_o,
  output logic                 last_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 err_o
);

  localparam int unsigned CntW = $clog2(AddrWidth);

  typedef logic [AddrWidth-1:0] addr_t;

  encode_state_e   state_q;
  addr_t           cursor_q;
  addr_t           end_q;

  addr_t           remaining;
  addr_t           size;
  addr_t           set_mask;
  logic            set_last;
  logic [CntW-1:0] tz_cnt;
  logic [CntW-1:0] lz_cnt;
  logic [CntW-1:0] fit_exp;
  logic [CntW-1:0] size_exp;
  logic            cursor_zero;
  logic            rem_zero;
  logic            req_bad;

  assign remaining = end_q - cursor_q;
  assign req_bad   = req_end_i <= req_start_i;

  lzc #(
    .Width   (AddrWidth),
    .Leading (1'b0)
  ) u_align_lzc (
    .data_i  (cursor_q),
    .cnt_o   (tz_cnt),
    .empty_o (cursor_zero)
  );

  lzc #(
    .Width   (AddrWidth),
    .Leading (1'b1)
  ) u_fit_lzc (
    .data_i  (remaining),
    .cnt_o   (lz_cnt),
    .empty_o (rem_zero)
  );

  // A zero cursor is aligned to everything, so only the remaining length bounds the set.
  always_comb begin
    fit_exp  = CntW'(AddrWidth - 1) - lz_cnt;
    size_exp = (cursor_zero || (tz_cnt > fit_exp)) ? fit_exp : tz_cnt;
    size     = addr_t'(1) << size_exp;
    set_mask = addr_t'(pow2_mask(wide_addr_t'(size)));
    set_last = !rem_zero && (size == remaining);
  end

  assign req_ready_o = (state_q == IDLE);
  assign valid_o     = (state_q == BUSY);
  assign addr_o      = valid_o ? cursor_q : '0;
  assign mask_o      = valid_o ? set_mask : '0;
  assign last_o      = valid_o & set_last;

  always_ff @(posedge clk_i) begin
    // NOTE: registered state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (!rst_ni) begin
      state_q  <= IDLE;
      cursor_q <= '0;
      end_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i && !req_bad) begin
            cursor_q <= req_start_i;
            end_q    <= req_end_i;
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          if (ready_i) begin
            cursor_q <= cursor_q + size;
            if (set_last) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef MULTIADDR_ENCODE_ERR_EN
  logic err_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= req_ready_o && req_valid_i && req_bad;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_multiaddr_range_encode.sv
// Randomised and directed bench for multiaddr_range_encode against a greedy set-splitting model.
module tb_multiaddr_range_encode;

  localparam int unsigned AW = 32;
  localparam longint unsigned ADDR_MAX = 64'hFFFF_FFFF;
`ifdef MULTIADDR_ENCODE_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] req_start;
  logic [AW-1:0] req_end;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] addr;
  logic [AW-1:0] mask;
  logic          last;
  logic          valid;
  logic          ready;
  logic          err;

  typedef struct {
    longint unsigned addr;
    longint unsigned mask;
    bit              last;
  } set_t;

  set_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  multiaddr_range_encode #(.AddrWidth(AW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_start_i (req_start),
    .req_end_i   (req_end),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .addr_o      (addr),
    .mask_o      (mask),
    .last_o      (last),
    .valid_o     (valid),
    .ready_i     (ready),
    .err_o       (err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Greedy cover: from the cursor, grow the block while it stays aligned and inside the interval.
  function automatic void model(input longint unsigned s, input longint unsigned e);
    longint unsigned cur = s;
    longint unsigned sz;
    while (cur < e) begin
      sz = 1;
      while (((cur % (sz * 2)) == 0) && (cur + sz * 2 <= e)) sz = sz * 2;
      exp_q.push_back('{addr: cur, mask: sz - 1, last: (cur + sz == e)});
      cur = cur + sz;
    end
  endfunction

  // mode 0: always ready; 1: random backpressure; 2: hold ready low 3 cycles on the second set.
  task automatic run_req(input longint unsigned s, input longint unsigned e, input int mode);
    int   guard = 0;
    int   idx   = 0;
    int   stall = 0;
    logic r;
    while (!req_ready && guard < 50) begin
      tick();
      guard++;
    end
    check("req_ready_wait", 64'(req_ready), 64'd1);
    req_start = s[AW-1:0];
    req_end   = e[AW-1:0];
    req_valid = 1'b1;
    ready     = 1'b0;
    tick();
    req_valid = 1'b0;
    if (e <= s) begin
      check("err_pulse", 64'(err), 64'(ERR_EXP));
      check("err_no_valid", 64'(valid), 64'd0);
      check("err_ready", 64'(req_ready), 64'd1);
      tick();
      check("err_clear", 64'(err), 64'd0);
      return;
    end
    model(s, e);
    guard = 0;
    while (exp_q.size() > 0 && guard < 4000) begin
      check("valid", 64'(valid), 64'd1);
      check("addr", 64'(addr), exp_q[0].addr);
      check("mask", 64'(mask), exp_q[0].mask);
      check("last", 64'(last), 64'(exp_q[0].last));
      case (mode)
        0:       r = 1'b1;
        1:       r = ($urandom_range(0, 2) != 0);
        default: begin
          r = !(idx == 1 && stall < 3);
          if (!r) stall++;
        end
      endcase
      ready = r;
      tick();
      guard++;
      if (r) begin
        void'(exp_q.pop_front());
        idx++;
      end
    end
    check("burst_done", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    ready = 1'b0;
    check("ready_after", 64'(req_ready), 64'd1);
    check("idle_valid", 64'(valid), 64'd0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    longint unsigned s;
    longint unsigned e;
    longint unsigned len;
    rst_n     = 1'b0;
    req_start = '0;
    req_end   = '0;
    req_valid = 1'b0;
    ready     = 1'b0;
    tick();
    tick();
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_addr", 64'(addr), 64'd0);
    check("rst_mask", 64'(mask), 64'd0);
    check("rst_last", 64'(last), 64'd0);
    rst_n = 1'b1;
    tick();

    run_req(64'h0, 64'h100, 0);
    run_req(64'h4, 64'h14, 0);
    run_req(64'h3, 64'h4, 0);
    run_req(64'h4, 64'h14, 2);
    run_req(64'h10, 64'h10, 0);
    run_req(64'h20, 64'h10, 0);
    run_req(64'h5, 64'h0, 0);
    run_req(64'h0, ADDR_MAX, 1);
    run_req(ADDR_MAX - 1, ADDR_MAX, 0);

    // Reset while the first set of a burst is on the output.
    req_start = 32'h0;
    req_end   = 32'h1000;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("mid_valid", 64'(valid), 64'd1);
    check("mid_mask", 64'(mask), 64'hFFF);
    rst_n = 1'b0;
    tick();
    check("mid_rst_valid", 64'(valid), 64'd0);
    check("mid_rst_ready", 64'(req_ready), 64'd1);
    check("mid_rst_addr", 64'(addr), 64'd0);
    check("mid_rst_mask", 64'(mask), 64'd0);
    check("mid_rst_last", 64'(last), 64'd0);
    rst_n = 1'b1;
    run_req(64'h8, 64'h10, 0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0:       s = longint'($urandom_range(0, 255));
        1:       s = longint'($urandom_range(0, 65535));
        default: s = longint'($urandom);
      endcase
      if ($urandom_range(0, 7) == 0) begin
        e = (s > 0) ? s - longint'($urandom_range(0, 3)) : 0;
        if (e > s) e = s;
      end else begin
        len = ($urandom_range(0, 1) == 0) ? longint'($urandom_range(1, 600))
                                          : longint'($urandom);
        if (len == 0) len = 1;
        e = s + len;
        if (e > ADDR_MAX) e = ADDR_MAX;
        if (e <= s) begin
          s = ADDR_MAX - 4;
          e = ADDR_MAX;
        end
      end
      run_req(s, e, int'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
